univ_shift_seq: RTL and testbench

Parametrised N-bit universal shift/rotate register with a multi-bit shift amount, executed one bit per clock under a start/busy/done handshake. Successor to the 4-bit single-step universal shift register. Adds the following:
- rotate and arithmetic-right modes
- serial fill inputs and a serial output
- programmable shift count
Sits in datapath blocks needing shared, low-area barrel-shift replacement.

---
 rtl/univ_shift_seq.sv | 157 +++++++++++++++
 tb/tb_univ_shift_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_seq.sv
// univ_shift_seq: N-bit universal shift/rotate register, one bit per clock.
// Multi-bit amount is executed serially under a start/busy/done handshake.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     request pulse, accepted when not busy (also accepted in DONE)
//   mode      3-bit operation select, latched on accept
//   amount    AW-bit shift count, latched on accept
//   data_in   parallel load value (load mode only)
//   ser_in_l  MSB fill for logical right shift, sampled every step
//   ser_in_r  LSB fill for logical left shift, sampled every step
//   data_out  register contents
//   ser_out   bit most recently shifted/rotated out
//   busy      high while stepping
//   done      one-cycle completion pulse
module univ_shift_seq #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  data_in,
  input  logic          ser_in_l,
  input  logic          ser_in_r,
  output logic [N-1:0]  data_out,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  state_t        state_q, state_n;
  logic [N-1:0]  data_q, data_n;
  logic          ser_q, ser_n;
  logic [AW-1:0] cnt_q, cnt_n;
  logic [2:0]    mode_q, mode_n;

  logic [N-1:0]  step_data;
  logic          step_ser;
  logic          req_shift;

  // Only the five real shift modes ever enter SHIFT; hold,
  // reserved and a zero count complete straight away.
  assign req_shift = (mode == M_SHL) || (mode == M_SHR) ||
                     (mode == M_ROL) || (mode == M_ROR) ||
                     (mode == M_ASR);

  // Single-bit step on the latched mode. Fill bits are taken
  // live from the ports at each step edge.
  always_comb begin
    step_data = data_q;
    step_ser  = ser_q;
    unique case (1'b1)
      (mode_q == M_SHL): begin
        step_data = {data_q[N-2:0], ser_in_r};
        step_ser  = data_q[N-1];
      end
      (mode_q == M_SHR): begin
        step_data = {ser_in_l, data_q[N-1:1]};
        step_ser  = data_q[0];
      end
      (mode_q == M_ROL): begin
        step_data = {data_q[N-2:0], data_q[N-1]};
        step_ser  = data_q[N-1];
      end
      (mode_q == M_ROR): begin
        step_data = {data_q[0], data_q[N-1:1]};
        step_ser  = data_q[0];
      end
      (mode_q == M_ASR): begin
        step_data = {data_q[N-1], data_q[N-1:1]};
        step_ser  = data_q[0];
      end
      default: begin
        step_data = data_q;
        step_ser  = ser_q;
      end
    endcase
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    ser_n   = ser_q;
    cnt_n   = cnt_q;
    mode_n  = mode_q;
    unique case (state_q)
      S_SHIFT: begin
        data_n = step_data;
        ser_n  = step_ser;
        cnt_n  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_n = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE with start gives
        // back-to-back operation.
        if (start) begin
          mode_n = mode;
          if (mode == M_LOAD) begin
            data_n  = data_in;
            state_n = S_DONE;
          end else if (req_shift && (amount != '0)) begin
            cnt_n   = amount;
            state_n = S_SHIFT;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      ser_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      ser_q   <= ser_n;
      cnt_q   <= cnt_n;
      mode_q  <= mode_n;
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign busy     = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_univ_shift_seq.sv
// tb_univ_shift_seq: bench for univ_shift_seq.
// Vector table, random ops against a reference model, handshake corners.
module tb_univ_shift_seq;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic [AW-1:0] amount = '0;
  logic [N-1:0]  data_in = '0;
  logic          ser_in_l = 1'b0;
  logic          ser_in_r = 1'b0;
  logic [N-1:0]  data_out;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_fail = 0;

  logic [N-1:0] m_data = '0;
  logic         m_ser = 1'b0;

  univ_shift_seq #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .amount(amount), .data_in(data_in), .ser_in_l(ser_in_l),
    .ser_in_r(ser_in_r), .data_out(data_out), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   m;
    int           a;
    logic [N-1:0] din;
    logic         sl;
    logic         sr;
    logic [N-1:0] ed;
    logic         es;
    int           eb;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int exp_busy(input logic [2:0] m, input int a);
    if ((m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) && a > 0) return a;
    return 0;
  endfunction

  // Whole-operation result from arithmetic on the start value.
  task automatic model(input logic [2:0] m, input int a,
                       input logic [N-1:0] din, input logic sl,
                       input logic sr);
    int d, mask, r, res, sgn;
    logic s;
    d    = int'(m_data);
    mask = (1 << N) - 1;
    res  = d;
    s    = m_ser;
    r    = a % N;
    sgn  = (d >> (N - 1)) & 1;
    case (m)
      3'd3: res = int'(din);
      3'd1: if (a > 0) begin
        s   = (a <= N) ? logic'((d >> (N - a)) & 1) : sr;
        res = (a >= N) ? (sr ? mask : 0)
            : (((d << a) | (sr ? ((1 << a) - 1) : 0)) & mask);
      end
      3'd2: if (a > 0) begin
        s   = (a <= N) ? logic'((d >> (a - 1)) & 1) : sl;
        res = (a >= N) ? (sl ? mask : 0)
            : ((d >> a) | (sl ? (mask & ~(mask >> a)) : 0));
      end
      3'd4: if (a > 0) begin
        res = ((d << r) | (d >> (N - r))) & mask;
        s   = logic'(res & 1);
      end
      3'd5: if (a > 0) begin
        res = ((d >> r) | (d << (N - r))) & mask;
        s   = logic'((res >> (N - 1)) & 1);
      end
      3'd6: if (a > 0) begin
        s   = (a <= N) ? logic'((d >> (a - 1)) & 1) : logic'(sgn);
        res = (a >= N) ? (sgn ? mask : 0)
            : ((d >> a) | (sgn ? (mask & ~(mask >> a)) : 0));
      end
      default: res = d;
    endcase
    m_data = N'(res);
    m_ser  = s;
  endtask

  task automatic wait_done(output int bcyc, output bit seen);
    bcyc = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) bcyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic do_op(input logic [2:0] m, input int a,
                       input logic [N-1:0] din, input logic sl,
                       input logic sr, output int bcyc,
                       output bit seen);
    @(negedge clk);
    chk("done_1cyc", done, 0);
    start    = 1'b1;
    mode     = m;
    amount   = AW'(a);
    data_in  = din;
    ser_in_l = sl;
    ser_in_r = sr;
    @(negedge clk);
    start = 1'b0;
    wait_done(bcyc, seen);
  endtask

  initial begin
    int  bc;
    bit  sn;
    logic [2:0] rm;
    int  ra;
    logic [N-1:0] rd;
    logic rsl, rsr;

    tbl[0]  = '{3'd3, 0,  8'hB5, 0, 0, 8'hB5, 0, 0};
    tbl[1]  = '{3'd4, 3,  8'h00, 0, 0, 8'hAD, 1, 3};
    tbl[2]  = '{3'd3, 0,  8'hB5, 0, 0, 8'hB5, 1, 0};
    tbl[3]  = '{3'd6, 2,  8'h00, 0, 0, 8'hED, 0, 2};
    tbl[4]  = '{3'd3, 0,  8'hB5, 0, 0, 8'hB5, 0, 0};
    tbl[5]  = '{3'd5, 8,  8'h00, 0, 0, 8'hB5, 1, 8};
    tbl[6]  = '{3'd1, 4,  8'h00, 0, 1, 8'h5F, 1, 4};
    tbl[7]  = '{3'd3, 0,  8'hFF, 0, 0, 8'hFF, 1, 0};
    tbl[8]  = '{3'd2, 7,  8'h00, 0, 0, 8'h01, 1, 7};
    tbl[9]  = '{3'd1, 0,  8'h00, 0, 1, 8'h01, 1, 0};
    tbl[10] = '{3'd7, 5,  8'h00, 1, 1, 8'h01, 1, 0};
    tbl[11] = '{3'd0, 3,  8'h00, 1, 1, 8'h01, 1, 0};
    tbl[12] = '{3'd3, 0,  8'h80, 0, 0, 8'h80, 1, 0};
    tbl[13] = '{3'd6, 15, 8'h00, 0, 0, 8'hFF, 1, 15};
    tbl[14] = '{3'd3, 0,  8'h5A, 0, 0, 8'h5A, 1, 0};
    tbl[15] = '{3'd2, 12, 8'h00, 1, 0, 8'hFF, 1, 12};
    tbl[16] = '{3'd3, 0,  8'h5A, 0, 0, 8'h5A, 1, 0};
    tbl[17] = '{3'd1, 10, 8'h00, 0, 0, 8'h00, 0, 10};
    tbl[18] = '{3'd3, 0,  8'hC1, 0, 0, 8'hC1, 0, 0};
    tbl[19] = '{3'd4, 9,  8'h00, 0, 0, 8'h83, 1, 9};

    #1 reset = 1'b0;
    #2;
    chk("rst_data", data_out, 0);
    chk("rst_ser", ser_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].m, tbl[i].a, tbl[i].din, tbl[i].sl, tbl[i].sr,
            bc, sn);
      model(tbl[i].m, tbl[i].a, tbl[i].din, tbl[i].sl, tbl[i].sr);
      chk($sformatf("tbl%0d_done", i), sn, 1);
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
      chk($sformatf("tbl%0d_ser", i), ser_out, tbl[i].es);
      chk($sformatf("tbl%0d_busy", i), bc, tbl[i].eb);
    end

    for (int i = 0; i < 80; i++) begin
      rm  = 3'($urandom_range(0, 7));
      ra  = $urandom_range(0, 15);
      rd  = N'($urandom);
      rsl = 1'($urandom);
      rsr = 1'($urandom);
      do_op(rm, ra, rd, rsl, rsr, bc, sn);
      model(rm, ra, rd, rsl, rsr);
      chk($sformatf("rnd%0d_done", i), sn, 1);
      chk($sformatf("rnd%0d_data", i), data_out, m_data);
      chk($sformatf("rnd%0d_ser", i), ser_out, m_ser);
      chk($sformatf("rnd%0d_busy", i), bc, exp_busy(rm, ra));
    end

    // start pulsed in the middle of a shift is ignored
    do_op(3'd3, 0, 8'hB5, 0, 0, bc, sn);
    @(negedge clk);
    start = 1'b1; mode = 3'd4; amount = AW'(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    start = 1'b1; mode = 3'd3; data_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, sn);
    chk("mid_done", sn, 1);
    chk("mid_data", data_out, 8'hAD);

    // start held through DONE gives back-to-back accept
    do_op(3'd3, 0, 8'hB5, 0, 0, bc, sn);
    @(negedge clk);
    start = 1'b1; mode = 3'd4; amount = AW'(1);
    @(negedge clk);
    chk("b2b_busy1", busy, 1);
    amount = AW'(2);
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_data1", data_out, 8'h6B);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    chk("b2b_nodone", done, 0);
    wait_done(bc, sn);
    chk("b2b_done2", sn, 1);
    chk("b2b_data2", data_out, 8'hAD);

    // fill input sampled live at every step
    do_op(3'd3, 0, 8'h00, 0, 0, bc, sn);
    @(negedge clk);
    start = 1'b1; mode = 3'd1; amount = AW'(4); ser_in_r = 1'b0;
    @(negedge clk);
    start = 1'b0; ser_in_r = 1'b1;
    @(negedge clk);
    ser_in_r = 1'b0;
    @(negedge clk);
    ser_in_r = 1'b1;
    @(negedge clk);
    ser_in_r = 1'b1;
    wait_done(bc, sn);
    chk("live_done", sn, 1);
    chk("live_data", data_out, 8'h0B);
    chk("live_ser", ser_out, 0);

    // reset during the second SHIFT cycle of a rotate
    @(negedge clk);
    start = 1'b1; mode = 3'd4; amount = AW'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_data", data_out, 0);
    chk("mrst_ser", ser_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mrst_hold_done", done, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_rel_done", done, 0);
    chk("mrst_rel_busy", busy, 0);
    do_op(3'd3, 0, 8'h3C, 0, 0, bc, sn);
    chk("mrst_load_done", sn, 1);
    chk("mrst_load_data", data_out, 8'h3C);
    chk("mrst_load_busy", bc, 0);
    @(negedge clk);
    chk("mrst_done_1cyc", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
